// File: rtl/dmem_responder.sv
// Single-port data memory responder with a valid/ready request and response handshake.
// It has a fixed response latency, byte-strobed stores, access-fault detection and a console MMIO word.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] PRINT_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        print_en,
  output logic [31:0] print_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        print_en_q, print_en_d;
  logic [31:0] print_data_q, print_data_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          is_print;
  logic          in_range;
  logic          fault;
  logic          mem_wr;
  logic [AW-1:0] mem_idx;

  assign is_print = (req_addr == PRINT_ADDR);
  assign in_range = (32'(req_addr[31:2]) < DEPTH_WORDS);
  assign fault    = (req_addr[1:0] != 2'b00) || (!in_range && !is_print);
  assign mem_idx  = req_addr[AW+1:2];
  assign accept   = req_valid && req_ready;
  assign mem_wr   = accept && req_write && !fault && !is_print;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    print_data_d = print_data_q;
    print_en_d   = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response payload is captured on the accept edge and held until consumed.
    if (accept) begin
      fault_d = fault;
      rdata_d = (fault || req_write || is_print) ? 32'd0 : mem[mem_idx];
      if (req_write && is_print && !fault && (req_wstrb != 4'd0)) begin
        print_en_d   = 1'b1;
        print_data_d = req_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rdata_q      <= 32'd0;
      fault_q      <= 1'b0;
      print_en_q   <= 1'b0;
      print_data_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      print_en_q   <= print_en_d;
      print_data_q <= print_data_d;
    end
  end

  // NOTE: the memory array has no reset; its contents survive rst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign print_en   = print_en_q;
  assign print_data = print_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: a LATENCY=2 instance for the main traffic,
// plus a LATENCY=0 instance for the zero-wait response timing.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] PADDR = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        print_en;
  logic [31:0] print_data;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_wstrb;
  logic        z_resp_valid, z_resp_ready, z_resp_fault;
  logic [31:0] z_resp_rdata;
  logic        z_print_en;
  logic [31:0] z_print_data;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .PRINT_ADDR(PADDR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .print_en(print_en), .print_data(print_data)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .PRINT_ADDR(PADDR)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_fault(z_resp_fault),
    .print_en(z_print_en), .print_data(z_print_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic        print;
    logic [31:0] pdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(int'(a[31:2]))) return model[int'(a[31:2])];
    return 32'hxxxx_xxxx;
  endfunction

  // One transaction on the LATENCY=2 instance; stall>0 holds resp_ready low and
  // presents a competing print store that must be ignored.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int stall);
    exp_t        e, got;
    logic        flt;
    logic [31:0] m;
    int          k;
    flt     = (a[1:0] != 2'b00) || ((32'(a[31:2]) >= DEPTH) && (a != PADDR));
    e.fault = flt;
    e.rdata = (flt || w || a == PADDR) ? 32'd0 : model_rd(a);
    e.print = !flt && w && (a == PADDR) && (s != 4'd0);
    e.pdata = d;
    if (!flt && w && a != PADDR) begin
      m = model_rd(a);
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      model[int'(a[31:2])] = m;
    end
    sb.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    k = 0;
    while (!req_ready && k < 32) begin @(negedge clk); k++; end
    check("req_ready before accept", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);

    k = 0;
    for (int i = 1; i <= 32 && k == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("print_en after accept", print_en, e.print);
        if (e.print) check("print_data", print_data, e.pdata);
      end else begin
        check("print_en one cycle only", print_en, 1'b0);
      end
      if (resp_valid) k = i;
    end
    check("resp latency cycles", 32'(k), LAT + 1);
    got = sb.pop_front();
    check("resp_rdata", resp_rdata, got.rdata);
    check("resp_fault", resp_fault, got.fault);

    if (stall > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = PADDR; req_wdata = 32'h0000_0BAD; req_wstrb = 4'hF;
      repeat (stall) begin
        @(negedge clk);
        check("stall resp_valid", resp_valid, 1'b1);
        check("stall resp_rdata", resp_rdata, got.rdata);
        check("stall req_ready", req_ready, 1'b0);
        check("stall ignored req", print_en, 1'b0);
      end
      req_valid = 1'b0;
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("resp_valid after handshake", resp_valid, 1'b0);
    check("req_ready after handshake", req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_wstrb = '0;
    z_resp_ready = 1'b0;

    #12;
    check("reset req_ready", req_ready, 1'b1);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_fault", resp_fault, 1'b0);
    check("reset print_en", print_en, 1'b0);
    check("reset print_data", print_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("req_ready after release", req_ready, 1'b1);

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5);
    check("partial store model", model_rd(32'h10), 32'hDEAD_BEAA);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 0);
    txn(1'b1, 4 * DEPTH, 32'h5555_5555, 4'hF, 0);
    txn(1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 0);
    txn(1'b1, 32'h10, 32'h1234_5678, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b1, PADDR, 32'h0000_0048, 4'hF, 0);
    txn(1'b1, PADDR, 32'h0000_0099, 4'h0, 0);
    txn(1'b0, PADDR, 32'h0, 4'h0, 0);
    txn(1'b1, 4 * (DEPTH - 1), 32'h0123_4567, 4'hF, 0);
    txn(1'b0, 4 * (DEPTH - 1), 32'h0, 4'h0, 0);
    txn(1'b0, 4 * DEPTH, 32'h0, 4'h0, 0);

    // Reset while a print store is waiting: outputs clear at once and no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = PADDR; req_wdata = 32'h55; req_wstrb = 4'hF;
    @(posedge clk);
    #2 req_valid = 1'b0;
    check("print_en before mid reset", print_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid reset resp_valid", resp_valid, 1'b0);
    check("mid reset resp_rdata", resp_rdata, 32'd0);
    check("mid reset resp_fault", resp_fault, 1'b0);
    check("mid reset print_en", print_en, 1'b0);
    check("mid reset print_data", print_data, 32'd0);
    check("mid reset req_ready", req_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("req_ready after mid reset", req_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check("no response after reset", resp_valid, 1'b0);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Zero-latency instance: response is valid on the cycle right after accept.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hCAFE_F00D; z_req_wstrb = 4'hF;
    check("lat0 req_ready", z_req_ready, 1'b1);
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    check("lat0 store resp_valid", z_resp_valid, 1'b1);
    check("lat0 store resp_rdata", z_resp_rdata, 32'd0);
    check("lat0 store resp_fault", z_resp_fault, 1'b0);
    z_resp_ready = 1'b1;
    @(posedge clk);
    #1 z_resp_ready = 1'b0;
    @(negedge clk);
    check("lat0 resp_valid drop", z_resp_valid, 1'b0);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h8; z_req_wstrb = 4'h0;
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    check("lat0 load resp_valid", z_resp_valid, 1'b1);
    check("lat0 load resp_rdata", z_resp_rdata, 32'hCAFE_F00D);
    z_resp_ready = 1'b1;
    @(posedge clk);
    #1 z_resp_ready = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the data memory size in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, giving the wait cycles between request accept and response (legal range 0-15).
REQ-003 SHALL have parameter PRINT_ADDR, default 32'h1000_0000, giving the console MMIO word address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, lane-aligned.
REQ-011 SHALL have port req_wstrb, input, 4 bits: byte-lane write enables, where bit n covers wdata[8n+7:8n].
REQ-012 SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-013 SHALL have port resp_ready, input, 1 bit: the initiator consumes the response.
REQ-014 SHALL have port resp_rdata, output, 32 bits: the full aligned load word.
REQ-015 SHALL have port resp_fault, output, 1 bit: access fault, qualified by resp_valid.
REQ-016 SHALL have port print_en, output, 1 bit: one-cycle console write strobe.
REQ-017 SHALL have port print_data, output, 32 bits: console data, qualified by print_en.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on a cycle where req_valid and req_ready are both 1.
REQ-021 SHALL, on accept with LATENCY>0, go to WAIT and load the wait counter with LATENCY-1.
REQ-022 SHALL, on accept with LATENCY=0, go directly to RESP.
REQ-023 SHALL, in WAIT, decrement the counter each cycle and go to RESP after the cycle in which the counter is 0, giving resp_valid exactly LATENCY+1 cycles after the accept edge.
REQ-024 SHALL, in RESP, hold resp_valid=1 and keep resp_rdata and resp_fault stable until resp_ready=1.
REQ-025 SHALL go to IDLE on the edge where resp_valid and resp_ready are both 1.
REQ-026 SHALL NOT accept a new request in that same cycle, because req_ready=0 in RESP; the minimum issue interval is LATENCY+2 cycles.
REQ-027 SHALL classify a request as a fault when req_addr[1:0]!=0, or when the word index is >= DEPTH_WORDS and req_addr!=PRINT_ADDR.
REQ-028 SHALL, for a faulting request, perform no memory write and no print, and respond with resp_fault=1 and resp_rdata=0.
REQ-029 SHALL, for a non-fault store to memory, write the strobed bytes on the accept edge; unstrobed bytes stay unchanged.
REQ-030 SHALL treat a store with wstrb=0 as a no-op that still responds with resp_fault=0.
REQ-031 SHALL, for a non-fault load from memory, capture the addressed word on the accept edge and ignore req_wstrb.
REQ-032 SHALL, for a store to PRINT_ADDR, pulse print_en=1 for the single cycle after the accept edge, with print_data=req_wdata and any nonzero wstrb.
REQ-033 SHALL, for a store to PRINT_ADDR with wstrb=0, not pulse print_en.
REQ-034 SHALL respond to a load from PRINT_ADDR with resp_rdata=0 and resp_fault=0.
REQ-035 SHALL respond to every store with resp_rdata=0.
REQ-036 SHALL index memory by req_addr[31:2] and SHALL NOT wrap addresses beyond the array; they fault per REQ-027.
REQ-037 SHALL ignore req_valid outside IDLE; the initiator holds the request until accepted.

Reset
REQ-038 SHALL, when rst is asserted at any time including mid-transaction, immediately force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_fault=0, print_en=0 and print_data=0.
REQ-039 SHALL drop a transaction in flight at reset with no response.
REQ-040 SHALL leave memory contents unchanged by reset.
REQ-041 SHALL present req_ready=1 on the first cycle after rst deasserts.

Verification
REQ-042 Scenario: store addr 0x10, data 0xDEADBEEF, wstrb 4'hF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_fault=0, resp_valid 3 cycles after each accept (LATENCY=2).
REQ-043 Scenario: store addr 0x10, data 0x000000AA, wstrb 4'b0001 over 0xDEADBEEF -> a later load returns 0xDEADBEAA.
REQ-044 Scenario: load 0x13, then store to 4*DEPTH_WORDS -> both give resp_fault=1 and resp_rdata=0, and memory and print_en are unchanged.
REQ-045 Scenario: store 0x48 to PRINT_ADDR with wstrb 4'hF -> print_en=1 for exactly one cycle with print_data=0x48, and the response has fault=0.
REQ-046 Scenario: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stay stable, and req_ready=0 throughout.
REQ-047 Scenario: rst asserted during WAIT -> outputs are zero asynchronously, no response follows, and req_ready=1 after release; LATENCY=0 build shows resp_valid on the cycle after accept.
